// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD up/down counter with prescaled tick and a time-multiplexed
// seven-segment scanner (shared segment lines, one-hot digit select).
module seven_segment_counter_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10_000_000,
    parameter int MUX_DIV  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int PW = $clog2(PRESCALE);
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         pre_reg, pre_next;
    logic [MW-1:0]         mux_reg, mux_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [4*DIGITS-1:0]   count_reg, count_next;
    logic                  wrap_reg, wrap_next;
    logic [6:0]            seg_reg, seg_next;
    logic                  dp_reg, dp_next;
    logic [DIGITS-1:0]     digit_sel_reg, digit_sel_next;

    logic [3:0]            digit_val [DIGITS];
    logic [DIGITS-1:0]     nib_zero;
    logic [DIGITS-1:0]     nib_nine;
    logic [DIGITS-1:0]     upper_zero;
    logic [4*DIGITS-1:0]   load_clamp;
    logic [4*DIGITS-1:0]   inc_val;
    logic [4*DIGITS-1:0]   dec_val;
    logic                  all_nine;
    logic                  all_zero;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Per-digit carry/borrow chain: a digit changes only when every lower digit wraps.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic carry_in;
            logic borrow_in;

            assign digit_val[gi]  = count_reg[gi*4 +: 4];
            assign nib_zero[gi]   = (digit_val[gi] == 4'd0);
            assign nib_nine[gi]   = (digit_val[gi] == 4'd9);
            assign upper_zero[gi] = &nib_zero[DIGITS-1:gi];
            assign load_clamp[gi*4 +: 4] =
                (load_val[gi*4 +: 4] > 4'd9) ? 4'd9 : load_val[gi*4 +: 4];

            if (gi == 0) begin : g_lsd
                assign carry_in  = 1'b1;
                assign borrow_in = 1'b1;
            end else begin : g_upper
                assign carry_in  = &nib_nine[gi-1:0];
                assign borrow_in = &nib_zero[gi-1:0];
            end

            assign inc_val[gi*4 +: 4] = !carry_in ? digit_val[gi] :
                                        (nib_nine[gi] ? 4'd0 : digit_val[gi] + 4'd1);
            assign dec_val[gi*4 +: 4] = !borrow_in ? digit_val[gi] :
                                        (nib_zero[gi] ? 4'd9 : digit_val[gi] - 4'd1);
        end
    endgenerate

    assign all_nine = &nib_nine;
    assign all_zero = &nib_zero;

    always_comb begin
        pre_next   = pre_reg;
        count_next = count_reg;
        wrap_next  = 1'b0;
        // Load outranks a coincident tick: no increment, no wrap.
        if (load) begin
            count_next = load_clamp;
            pre_next   = '0;
        end else if (en) begin
            if (pre_reg == PRE_LAST) begin
                pre_next   = '0;
                count_next = up_dn ? inc_val : dec_val;
                wrap_next  = up_dn ? all_nine : all_zero;
            end else begin
                pre_next = pre_reg + 1'b1;
            end
        end
    end

    always_comb begin
        mux_next = mux_reg;
        idx_next = idx_reg;
        if (mux_reg == MUX_LAST) begin
            mux_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
            mux_next = mux_reg + 1'b1;
        end
    end

    // Display stage works from the registered index and count, one cycle behind them.
    always_comb begin
        digit_sel_next = DIGITS'(1) << idx_reg;
        seg_next       = seg_decode(digit_val[idx_reg]);
        dp_next        = (idx_reg == '0) && !en;
        if ((BLANK_LZ != 0) && (idx_reg != '0) && upper_zero[idx_reg]) begin
            seg_next = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg       <= '0;
            mux_reg       <= '0;
            idx_reg       <= '0;
            count_reg     <= '0;
            wrap_reg      <= 1'b0;
            seg_reg       <= 7'h00;
            dp_reg        <= 1'b0;
            digit_sel_reg <= '0;
        end else begin
            pre_reg       <= pre_next;
            mux_reg       <= mux_next;
            idx_reg       <= idx_next;
            count_reg     <= count_next;
            wrap_reg      <= wrap_next;
            seg_reg       <= seg_next;
            dp_reg        <= dp_next;
            digit_sel_reg <= digit_sel_next;
        end
    end

    assign seg       = seg_reg;
    assign dp        = dp_reg;
    assign digit_sel = digit_sel_reg;
    assign count_bcd = count_reg;
    assign wrap      = wrap_reg;

endmodule
